// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and the lane masks used to build byte enables.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Lane masks before shifting to the addressed lane.
    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a 32-bit little-endian data memory:
// store byte enables and data replication, load extract/extend, and
// detection of misaligned or reserved-size accesses.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    // Flag accesses that cannot be served: unaligned half/word or reserved size.
    always_comb begin
        misalign_o = 1'b0;
        case (size_i)
            SIZE_HALF: misalign_o = addr_lo_i[0];
            SIZE_WORD: misalign_o = |addr_lo_i;
            SIZE_RSVD: misalign_o = 1'b1;
            default:   misalign_o = 1'b0;
        endcase
    end

    // Store side: replicate the right-aligned data into every lane and
    // enable only the lanes the access covers; errors write nothing.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = LANES_BYTE << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                be_o    = LANES_HALF << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                be_o    = LANES_WORD;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
        if (misalign_o) begin
            be_o = 4'b0000;
        end
    end

    // Load side: pick the addressed lane(s) and sign/zero extend; errors read 0.
    always_comb begin
        rdata_o = '0;
        case (size_i)
            SIZE_BYTE: rdata_o = {{24{~is_unsigned_i & rword_i[{addr_lo_i, 3'b000} + 7]}},
                                  rword_i[{addr_lo_i, 3'b000} +: 8]};
            SIZE_HALF: rdata_o = {{16{~is_unsigned_i & rword_i[{addr_lo_i[1], 4'b0000} + 15]}},
                                  rword_i[{addr_lo_i[1], 4'b0000} +: 16]};
            SIZE_WORD: rdata_o = rword_i;
            default:   rdata_o = '0;
        endcase
        if (misalign_o) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: accepts one load/store at a time,
// holds it for WAIT_CYCLES wait states, commits to a word array and returns
// a registered one-cycle response while stalling the pipeline meanwhile.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Counter holds WAIT_CYCLES-1 down to 0.
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [DEPTH_LOG2+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    resp_valid_q;
    logic [31:0]             resp_rdata_q;
    logic                    resp_err_q;

    logic                    idle;
    logic                    accept;
    logic                    commit;
    logic                    cur_wr;
    logic [1:0]              cur_size;
    logic                    cur_uns;
    logic [DEPTH_LOG2+1:0]   cur_addr;
    logic [31:0]             cur_wdata;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [31:0]             rword;
    logic                    misalign;
    logic [3:0]              be;
    logic [31:0]             st_data;
    logic [31:0]             ld_data;
    logic                    unused_addr_hi;

    // Address bits above the array are deliberately ignored (aliasing).
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

    assign idle   = (state_q == S_IDLE);
    assign accept = req_valid & idle;

    // In IDLE the live request is used directly so a zero-wait access can
    // commit on its accept edge; afterwards the latched copy is used.
    assign cur_wr    = idle ? req_wr                     : wr_q;
    assign cur_size  = idle ? req_size                   : size_q;
    assign cur_uns   = idle ? req_unsigned               : uns_q;
    assign cur_addr  = idle ? req_addr[DEPTH_LOG2+1:0]   : addr_q;
    assign cur_wdata = idle ? req_wdata                  : wdata_q;
    assign word_idx  = cur_addr[DEPTH_LOG2+1:2];

    // Commit happens on the edge that moves the FSM into RESP.
    always_comb begin
        commit = 1'b0;
        if (idle) begin
            commit = accept && (WAIT_CYCLES == 0);
        end else if (state_q == S_WAIT) begin
            commit = (cnt_q == '0);
        end
    end

    mem_lane_align u_align (
        .size_i        (cur_size),
        .addr_lo_i     (cur_addr[1:0]),
        .is_unsigned_i (cur_uns),
        .wdata_i       (cur_wdata),
        .rword_i       (rword),
        .misalign_o    (misalign),
        .be_o          (be),
        .wdata_o       (st_data),
        .rdata_o       (ld_data)
    );

    // One byte-wide array per lane so each lane has its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Lane write on commit; a reset on the same edge drops the store.
        always_ff @(posedge clk) begin
            if (!rst && commit && cur_wr && be[gi]) begin
                lane_mem[word_idx] <= st_data[gi*8 +: 8];
            end
        end

        assign rword[gi*8 +: 8] = lane_mem[word_idx];
    end

    // Control FSM with request latch, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= commit;
            if (commit) begin
                resp_err_q   <= misalign;
                resp_rdata_q <= cur_wr ? '0 : ld_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        wr_q    <= req_wr;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr[DEPTH_LOG2+1:0];
                        wdata_q <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = idle;
    assign stall      = (idle & req_valid) | (state_q == S_WAIT);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 2 wait states), directed
// scenarios plus randomized traffic against a byte-level memory model.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=0 instance, index 1: WAIT_CYCLES=2 instance.
    logic        req_valid_a    [2];
    logic        req_wr_a       [2];
    logic [1:0]  req_size_a     [2];
    logic        req_unsigned_a [2];
    logic [31:0] req_addr_a     [2];
    logic [31:0] req_wdata_a    [2];
    logic        req_ready_a    [2];
    logic        resp_valid_a   [2];
    logic [31:0] resp_rdata_a   [2];
    logic        resp_err_a     [2];
    logic        stall_a        [2];

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[0]), .req_wr(req_wr_a[0]), .req_size(req_size_a[0]),
        .req_unsigned(req_unsigned_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .req_ready(req_ready_a[0]), .resp_valid(resp_valid_a[0]), .resp_rdata(resp_rdata_a[0]),
        .resp_err(resp_err_a[0]), .stall(stall_a[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[1]), .req_wr(req_wr_a[1]), .req_size(req_size_a[1]),
        .req_unsigned(req_unsigned_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .req_ready(req_ready_a[1]), .resp_valid(resp_valid_a[1]), .resp_rdata(resp_rdata_a[1]),
        .resp_err(resp_err_a[1]), .stall(stall_a[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory contents, one array per instance.
    logic [31:0] mdl [2][1024];

    function automatic int waits_of(input int w);
        return (w == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        req_valid_a[w]    = v;
        req_wr_a[w]       = wr;
        req_size_a[w]     = sz;
        req_unsigned_a[w] = uns;
        req_addr_a[w]     = a;
        req_wdata_a[w]    = wd;
    endtask

    // Behavioural model: byte-addressed little-endian word store.
    task automatic model_op(input int w, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output logic exp_err);
        int off, idx, nb;
        logic [31:0] v;
        off = int'(a % 4);
        idx = int'((a / 4) % 1024);
        exp_err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        exp_rd = 32'h0;
        if (!exp_err) begin
            nb = 1 << sz;
            if (wr) begin
                for (int b = 0; b < nb; b++) begin
                    mdl[w][idx][(off + b) * 8 +: 8] = wd[b * 8 +: 8];
                end
            end else begin
                v = mdl[w][idx] >> (8 * off);
                if (nb == 1) begin
                    v = v & 32'hFF;
                    if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end
                exp_rd = v;
            end
        end
    endtask

    // One complete request/response with latency, stall and data checks.
    task automatic run_op(input int w, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat, stalls;
        bit          seen;
        string       tag;
        model_op(w, wr, sz, uns, a, wd, exp_rd, exp_err);
        tag = $sformatf("w%0d %s sz%0d u%0b @%08h", waits_of(w), wr ? "st" : "ld", sz, uns, a);
        @(negedge clk);
        drive(w, 1'b1, wr, sz, uns, a, wd);
        #1;
        lat = 0;
        seen = 1'b0;
        stalls = stall_a[w] ? 1 : 0;
        while (!seen && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid_a[w]) seen = 1'b1;
            else if (stall_a[w]) stalls++;
        end
        got = resp_rdata_a[w];
        if (seen) begin
            chk({tag, " latency"}, lat, waits_of(w) + 1);
            chk({tag, " stall cycles"}, stalls, waits_of(w) + 1);
            chk({tag, " rdata"}, resp_rdata_a[w], exp_rd);
            chk({tag, " err"}, {31'b0, resp_err_a[w]}, {31'b0, exp_err});
            chk({tag, " stall in resp"}, {31'b0, stall_a[w]}, 32'd0);
            chk({tag, " ready in resp"}, {31'b0, req_ready_a[w]}, 32'd0);
        end else begin
            chk({tag, " response timeout"}, 32'd0, 32'd1);
        end
        $display("txn %s wdata=%08h rdata=%08h err=%0b lat=%0d", tag, wd, got, resp_err_a[w], lat);
        @(negedge clk);
        req_valid_a[w] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] a;

        for (int w = 0; w < 2; w++) drive(w, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        req_valid_a[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("reset w%0d resp_valid", w), {31'b0, resp_valid_a[w]}, 32'd0);
            chk($sformatf("reset w%0d resp_rdata", w), resp_rdata_a[w], 32'd0);
            chk($sformatf("reset w%0d resp_err", w), {31'b0, resp_err_a[w]}, 32'd0);
            chk($sformatf("reset w%0d req_ready", w), {31'b0, req_ready_a[w]}, 32'd1);
            chk($sformatf("reset w%0d stall", w), {31'b0, stall_a[w]}, {31'b0, req_valid_a[w]});
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid_a[1] = 1'b0;

        // Word store then load, two wait states.
        run_op(1, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
        run_op(1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, got);
        chk("lw 0x10", got, 32'hDEAD_BEEF);

        // Byte merge and sub-word loads.
        run_op(1, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h1122_3344, got);
        run_op(1, 1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h0000_00AA, got);
        run_op(1, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, got);
        chk("lw after sb", got, 32'h1122_AA44);
        run_op(1, 1'b0, SIZE_BYTE, 1'b0, 32'h21, 32'h0, got);
        chk("lb 0x21", got, 32'hFFFF_FFAA);
        run_op(1, 1'b0, SIZE_BYTE, 1'b1, 32'h21, 32'h0, got);
        chk("lbu 0x21", got, 32'h0000_00AA);
        run_op(1, 1'b0, SIZE_HALF, 1'b0, 32'h22, 32'h0, got);
        chk("lh 0x22", got, 32'h0000_1122);

        // Misaligned accesses: error, no write.
        run_op(1, 1'b0, SIZE_HALF, 1'b0, 32'h23, 32'h0, got);
        chk("lh 0x23 rdata", got, 32'h0);
        run_op(1, 1'b1, SIZE_WORD, 1'b0, 32'h22, 32'hCAFE_F00D, got);
        run_op(1, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, got);
        chk("lw after errors", got, 32'h1122_AA44);

        // Zero wait states, request held high across four loads.
        run_op(0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h1122_3344, got);
        model_op(0, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, exp_rd, exp_err);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b stall cyc%0d", i), {31'b0, stall_a[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b resp_valid cyc%0d", i), {31'b0, resp_valid_a[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                chk($sformatf("b2b rdata cyc%0d", i), resp_rdata_a[0], exp_rd);
                chk($sformatf("b2b rdata lit cyc%0d", i), resp_rdata_a[0], 32'h1122_3344);
                $display("txn w0 b2b ld @00000020 rdata=%08h", resp_rdata_a[0]);
            end
        end
        @(negedge clk);
        req_valid_a[0] = 1'b0;

        // Reset during WAIT drops the pending store.
        run_op(1, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0BAD_F00D, got);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0000_0055);
        @(posedge clk);
        #1;
        chk("abort accepted stall", {31'b0, stall_a[1]}, 32'd1);
        chk("abort accepted ready", {31'b0, req_ready_a[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req_valid_a[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("abort ready after rst", {31'b0, req_ready_a[1]}, 32'd1);
        chk("abort resp_valid in rst", {31'b0, resp_valid_a[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort no resp cyc%0d", i), {31'b0, resp_valid_a[1]}, 32'd0);
        end
        $display("txn w2 aborted st @00000040 wdata=00000055");
        run_op(1, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, got);
        chk("lw after abort", got, 32'h0BAD_F00D);

        // Aliasing of high address bits.
        for (int w = 0; w < 2; w++) begin
            run_op(w, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h1234_5678, got);
            run_op(w, 1'b0, SIZE_WORD, 1'b0, 32'h0000_1000, 32'h0, got);
            chk($sformatf("alias w%0d", waits_of(w)), got, 32'h1234_5678);
        end

        // Randomized traffic over sixteen words after initialising them.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                a = ($urandom() & 32'hFFFF_F000) | (i << 2);
                run_op(w, 1'b1, SIZE_WORD, 1'b0, a, $urandom(), got);
            end
            for (int i = 0; i < 120; i++) begin
                a = ($urandom() & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                run_op(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), a, $urandom(), got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
